// File: rtl/data_island_scheduler_if.sv
// Handshake bundle between the data-island scheduler, the audio buffer's
// occupancy count and the hdmi core's packet_type input.
interface data_island_scheduler_if #(
  parameter int unsigned FIFO_DEPTH_BITS = 8
);
  logic                       frame_start;
  logic                       packet_enable;
  logic [FIFO_DEPTH_BITS-1:0] audio_remaining;
  logic                       avi_enable;
  logic                       audio_info_enable;
  logic [7:0]                 packet_type;
  logic                       audio_pop;
  logic [7:0]                 frame_packet_count;

  modport master (
    output frame_start, packet_enable, audio_remaining, avi_enable, audio_info_enable,
    input  packet_type, audio_pop, frame_packet_count
  );

  modport slave (
    input  frame_start, packet_enable, audio_remaining, avi_enable, audio_info_enable,
    output packet_type, audio_pop, frame_packet_count
  );
endinterface

// File: rtl/data_island_scheduler.sv
// Picks the packet type for each data-island slot: ACR every Nth frame, one AVI and
// one Audio InfoFrame per frame, audio samples otherwise (urgent audio beats InfoFrames).
module data_island_scheduler #(
  parameter int unsigned                ACR_FRAME_INTERVAL = 1,
  parameter int unsigned                FIFO_DEPTH_BITS    = 8,
  parameter logic [FIFO_DEPTH_BITS-1:0] AUDIO_URGENT_LEVEL = FIFO_DEPTH_BITS'(192)
) (
  input  logic                    clk_pixel_i,
  input  logic                    reset_i,
  data_island_scheduler_if.slave  bus
);

  typedef enum logic [7:0] {
    PT_NULL = 8'h00,
    PT_ACR  = 8'h01,
    PT_AUD  = 8'h02,
    PT_AVI  = 8'h82,
    PT_AIF  = 8'h84
  } pkt_e;

  localparam logic [7:0] ACR_LAST = 8'(ACR_FRAME_INTERVAL - 1);

  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       acr_q, acr_d;
  logic       avi_q, avi_d;
  logic       aif_q, aif_d;
  logic [7:0] run_q, run_d;
  logic [7:0] fpc_q, fpc_d;
  pkt_e       type_q, type_d;
  logic       pop_q, pop_d;
  pkt_e       sel;
  logic       urgent;

  assign urgent = bus.audio_remaining >= AUDIO_URGENT_LEVEL;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    acr_d       = acr_q;
    avi_d       = avi_q;
    aif_d       = aif_q;
    run_d       = run_q;
    fpc_d       = fpc_q;
    type_d      = type_q;
    pop_d       = 1'b0;
    sel         = PT_NULL;

    // Frame bookkeeping first so a coincident packet_enable sees the fresh frame.
    if (bus.frame_start) begin
      if (frame_cnt_q == ACR_LAST) begin
        frame_cnt_d = 8'd0;
        acr_d       = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
      avi_d = bus.avi_enable;
      aif_d = bus.audio_info_enable;
      fpc_d = run_q;
      run_d = 8'd0;
    end

    if (acr_d)                                sel = PT_ACR;
    else if (urgent)                          sel = PT_AUD;
    else if (avi_d && bus.avi_enable)         sel = PT_AVI;
    else if (aif_d && bus.audio_info_enable)  sel = PT_AIF;
    else if (bus.audio_remaining != '0)       sel = PT_AUD;
    else                                      sel = PT_NULL;

    if (bus.packet_enable) begin
      type_d = sel;
      pop_d  = (sel == PT_AUD);
      case (sel)
        PT_ACR:  acr_d = 1'b0;
        PT_AVI:  avi_d = 1'b0;
        PT_AIF:  aif_d = 1'b0;
        default: ;
      endcase
      if (sel != PT_NULL && run_d != 8'hff) run_d = run_d + 8'd1;
    end
  end

  always_ff @(posedge clk_pixel_i) begin
    if (reset_i) begin
      frame_cnt_q <= 8'd0;
      acr_q       <= 1'b1;
      avi_q       <= bus.avi_enable;
      aif_q       <= bus.audio_info_enable;
      run_q       <= 8'd0;
      fpc_q       <= 8'd0;
      type_q      <= PT_NULL;
      pop_q       <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      acr_q       <= acr_d;
      avi_q       <= avi_d;
      aif_q       <= aif_d;
      run_q       <= run_d;
      fpc_q       <= fpc_d;
      type_q      <= type_d;
      pop_q       <= pop_d;
    end
  end

  assign bus.packet_type        = type_q;
  assign bus.audio_pop          = pop_q;
  assign bus.frame_packet_count = fpc_q;

endmodule

// File: doc/data_island_scheduler.md
Name: data_island_scheduler

Overview:
- Selects the packet type sent in each HDMI data-island slot offered by the hdmi core's packet_enable strobe.
- Per frame, it schedules Audio Clock Regeneration (0x01) at a programmable frame interval, plus one AVI InfoFrame (0x82) and one Audio InfoFrame (0x84).
- It drains audio samples (0x02) from the audio buffer, and audio preempts InfoFrames when the buffer nears full.
- It sits in clk_pixel between the audio buffer's remaining count and the hdmi core's packet_type input, and replaces ad-hoc top-level scheduling logic.

Parameters:
- ACR_FRAME_INTERVAL, 1, ACR is sent on every Nth frame; legal range 1..255.
- AUDIO_URGENT_LEVEL, 8'd192, at or above this remaining count, audio beats InfoFrames; ACR is never preempted.
- FIFO_DEPTH_BITS, 8, width of audio_remaining.

Ports:
- clk_pixel  input  1  pixel clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- frame_start  input  1  one-cycle pulse at cx==0, cy==0.
- packet_enable  input  1  one-cycle pulse from the hdmi core: choose the next packet now.
- audio_remaining  input  FIFO_DEPTH_BITS  samples waiting in the audio buffer.
- avi_enable  input  1  quasi-static; when 0, the AVI InfoFrame is never scheduled.
- audio_info_enable  input  1  quasi-static; when 0, the Audio InfoFrame is never scheduled.
- packet_type  output  8  header type fed to the hdmi core.
- audio_pop  output  1  one-cycle strobe: the buffer advances one sample.
- frame_packet_count  output  8  packets of any non-null type issued in the previous frame; saturates at 255.

Behaviour:
- Reset (synchronous, active-high):
  - packet_type = 0x00, audio_pop = 0, frame_packet_count = 0.
  - frame counter = 0.
  - acr_pending = 1, avi_pending = avi_enable, aif_pending = audio_info_enable.
  - running packet counter = 0.
  - reset dominates all other inputs on the same cycle.
- Frame handling on frame_start:
  - frame counter = (frame counter == ACR_FRAME_INTERVAL-1) ? 0 : +1.
  - acr_pending is set when the counter wraps to 0.
  - avi_pending = avi_enable, aif_pending = audio_info_enable.
  - frame_packet_count is loaded from the running counter; the running counter clears to 0.
  - A pending flag still set at frame_start is simply re-armed; nothing is queued twice.
- Effective flags:
  - The effective value of each flag is its next-state value after frame_start is applied.
  - When frame_start and packet_enable coincide, selection uses the fresh frame's flags.
  - The running counter clears, then counts the coincident packet, so it ends at 1 if that packet is non-null.
- Selection on packet_enable, evaluated in priority order:
  1. acr_pending: packet_type = 0x01, clear acr_pending.
  2. audio_remaining >= AUDIO_URGENT_LEVEL: packet_type = 0x02, pulse audio_pop.
  3. avi_pending && avi_enable: packet_type = 0x82, clear avi_pending.
  4. aif_pending && audio_info_enable: packet_type = 0x84, clear aif_pending.
  5. audio_remaining > 0: packet_type = 0x02, pulse audio_pop.
  6. Otherwise: packet_type = 0x00.
- Deasserting an enable mid-frame suppresses that InfoFrame immediately.
- Timing:
  - packet_type and audio_pop are registered; both update on the clock edge that samples packet_enable, so latency is 1 cycle.
  - packet_type holds its value between packet_enable pulses.
  - audio_pop is high for exactly one cycle per audio selection and never without a packet_enable.
- Pop budget:
  - Since pop is registered, audio_remaining may lag by 1 cycle.
  - packet_enable pulses are at least 32 cycles apart, so no double pop occurs on stale counts.
- Running counter: increments for each selection with packet_type != 0x00 and saturates at 255.

Test Plan:
- Reset, then frame_start, then 4 packet_enable pulses, with audio_remaining=0 and both enables=1 -> packet_type sequence 0x01, 0x82, 0x84, 0x00; audio_pop never asserted.
- audio_remaining=5 held; after the 0x01/0x82/0x84 triple, 3 more pulses -> 0x02 three times; audio_pop pulses 3 times, each 1 cycle, aligned with the packet_type update.
- audio_remaining=200 with AUDIO_URGENT_LEVEL=192, in a new frame -> 0x01, then 0x02 preempting 0x82; after remaining drops to 100 -> 0x82, 0x84, 0x02.
- ACR_FRAME_INTERVAL=3 across 6 frames, first packet of each frame -> ACR appears in the frame after reset and in frames 3 and 6; other frames start with 0x82.
- frame_start coincident with packet_enable while aif_pending was still set from the prior frame -> packet_type = 0x01 if ACR is due, else 0x82; frame_packet_count = prior frame's total; running counter = 1.
- Reset asserted mid-frame while audio_remaining=10 -> the next cycle shows packet_type=0x00, audio_pop=0, frame_packet_count=0; the first subsequent packet_enable yields 0x01.
